// File: rtl/muldiv_unit.sv
// Iterative multiply / divide / multiply-accumulate unit for the EX stage (HI/LO producer).
// Latency: WIDTH+2 cycles from start to done_o (2 cycles for divide-by-zero); one bit per cycle.
// Backpressure: stall_req_o holds the pipeline from the start cycle until the result strobe; start_i is ignored while busy.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start_i, annul_i   launch request (IDLE only) / abort of the in-flight operation
//   op_i               000 MULT 001 MULTU 010 DIV 011 DIVU 100 MADD 101 MADDU 110 MSUB 111 MSUBU
//   opa_i, opb_i       rs / rt operands (dividend / divisor), sampled only at launch
//   hi_i, lo_i         forwarded HI/LO, accumulator for MADD/MSUB, sampled only at launch
//   busy_o             unit not idle
//   stall_req_o        pipeline stall request
//   done_o             one-cycle result strobe
//   hi_o, lo_o         result (remainder / quotient for divides), held until the next result
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             annul_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic             busy_o,
    output logic             stall_req_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Operation latched at launch
    logic               r_is_div;
    logic               r_mac;
    logic               r_sub;
    logic               r_div0;
    logic               r_neg;      // product / quotient sign
    logic               r_rneg;     // remainder sign (dividend sign)
    logic [WIDTH-1:0]   r_a;        // multiplicand magnitude; raw dividend on divide-by-zero
    logic [WIDTH-1:0]   r_b;        // divisor magnitude
    logic [2*WIDTH-1:0] r_acc;      // {HI, LO} accumulator
    logic [2*WIDTH-1:0] r_work;     // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Launch decode
    logic             w_is_div;
    logic             w_signed;
    logic             w_div0;
    logic             w_start;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_amag;
    logic [WIDTH-1:0] w_bmag;

    assign w_is_div = (op_i[2:1] == 2'b01);
    assign w_signed = ~op_i[0];
    assign w_div0   = w_is_div && (opb_i == '0);
    assign w_start  = start_i && (r_state == S_IDLE) && !annul_i;
    assign w_a_neg  = w_signed && opa_i[WIDTH-1];
    assign w_b_neg  = w_signed && opb_i[WIDTH-1];
    // The most-negative value negates to itself, which read unsigned is exactly its magnitude.
    assign w_amag   = w_a_neg ? -opa_i : opa_i;
    assign w_bmag   = w_b_neg ? -opb_i : opb_i;

    // One shift-add multiply step: add the multiplicand into the high half when the
    // current multiplier bit is set, then shift the whole product right one place.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;

    assign w_mul_sum  = {1'b0, r_work[2*WIDTH-1:WIDTH]} + {1'b0, (r_work[0] ? r_a : {WIDTH{1'b0}})};
    assign w_mul_step = {w_mul_sum, r_work[WIDTH-1:1]};

    // One restoring divide step on the shifted (2*WIDTH+1)-bit value: the top WIDTH+1
    // bits are the trial remainder; subtract the divisor if it fits and shift in a 1.
    logic [2*WIDTH:0]   w_div_sh;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_sub;
    logic [2*WIDTH-1:0] w_div_step;

    assign w_div_sh   = {r_work, 1'b0};
    assign w_div_ge   = w_div_sh[2*WIDTH:WIDTH] >= {1'b0, r_b};
    assign w_div_sub  = w_div_sh[2*WIDTH-1:WIDTH] - r_b;
    assign w_div_step = w_div_ge ? {w_div_sub, w_div_sh[WIDTH-1:1], 1'b1} : w_div_sh[2*WIDTH-1:0];

    // Final sign fix-up and accumulate
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_mac;
    logic [WIDTH-1:0]   w_quo_s;
    logic [WIDTH-1:0]   w_rem_s;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_prod_s = r_neg ? -r_work : r_work;
    assign w_mac    = r_mac ? (r_sub ? (r_acc - w_prod_s) : (r_acc + w_prod_s)) : w_prod_s;
    // Most-negative / -1 needs no special case: magnitude quotient 2^(WIDTH-1) negates to itself.
    assign w_quo_s  = r_neg  ? -r_work[WIDTH-1:0]       : r_work[WIDTH-1:0];
    assign w_rem_s  = r_rneg ? -r_work[2*WIDTH-1:WIDTH] : r_work[2*WIDTH-1:WIDTH];

    always_comb begin
        w_res_hi = w_mac[2*WIDTH-1:WIDTH];
        w_res_lo = w_mac[WIDTH-1:0];
        if (r_div0) begin
            w_res_hi = r_a;
            w_res_lo = '1;
        end else if (r_is_div) begin
            w_res_hi = w_rem_s;
            w_res_lo = w_quo_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy_o      = (r_state != S_IDLE);
        done_o      = (r_state == S_DONE);
        stall_req_o = w_start || (r_state == S_RUN) || (r_state == S_FIN);
        if (annul_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start_i) w_state_nxt = w_div0 ? S_FIN : S_RUN;
                S_RUN:   if (r_cnt == C_LAST) w_state_nxt = S_FIN;
                S_FIN:   w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_div <= 1'b0;
            r_mac    <= 1'b0;
            r_sub    <= 1'b0;
            r_div0   <= 1'b0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_work   <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            if (w_start) begin
                r_is_div <= w_is_div;
                r_mac    <= op_i[2];
                r_sub    <= op_i[1];
                r_div0   <= w_div0;
                r_neg    <= w_a_neg ^ w_b_neg;
                r_rneg   <= w_a_neg;
                r_a      <= w_div0 ? opa_i : w_amag;
                r_b      <= w_bmag;
                r_acc    <= {hi_i, lo_i};
                r_work   <= {{WIDTH{1'b0}}, (w_is_div ? w_amag : w_bmag)};
                r_cnt    <= '0;
            end else if ((r_state == S_RUN) && !annul_i) begin
                r_work <= r_is_div ? w_div_step : w_mul_step;
                r_cnt  <= r_cnt + CNT_W'(1);
            end
            // Results move only on the FIN->DONE edge; an annul leaves the last result intact.
            if ((r_state == S_FIN) && !annul_i) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a 32-bit and an 8-bit instance share stimulus.
// Reference results come from plain signed/unsigned arithmetic on sign-extended integers.
// Index 0 of the observation arrays is the 32-bit instance, index 1 the 8-bit one.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst32, rst8;
    logic        start_i, annul_i;
    logic [2:0]  op_i;
    logic [31:0] opa_i, opb_i, hi_i, lo_i;

    logic        busy32, stall32, done32;
    logic [31:0] hi32, lo32;
    logic        busy8, stall8, done8;
    logic [7:0]  hi8, lo8;

    logic [1:0]  busy_v, stall_v, done_v;
    logic [63:0] res_v [2];

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_prev [2];

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst32), .start_i(start_i), .annul_i(annul_i), .op_i(op_i),
        .opa_i(opa_i), .opb_i(opb_i), .hi_i(hi_i), .lo_i(lo_i),
        .busy_o(busy32), .stall_req_o(stall32), .done_o(done32), .hi_o(hi32), .lo_o(lo32)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .start_i(start_i), .annul_i(annul_i), .op_i(op_i),
        .opa_i(opa_i[7:0]), .opb_i(opb_i[7:0]), .hi_i(hi_i[7:0]), .lo_i(lo_i[7:0]),
        .busy_o(busy8), .stall_req_o(stall8), .done_o(done8), .hi_o(hi8), .lo_o(lo8)
    );

    assign busy_v  = {busy8, busy32};
    assign stall_v = {stall8, stall32};
    assign done_v  = {done8, done32};

    always_comb begin
        res_v[0] = {hi32, lo32};
        res_v[1] = {24'b0, hi8, 24'b0, lo8};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int w_of(input int k);
        return (k == 0) ? 32 : 8;
    endfunction

    // Result packed as {hi (32 bits), lo (32 bits)}, each zero-extended from w bits.
    function automatic logic [63:0] ref_model(input int w, input logic [2:0] op,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] h, input logic [31:0] l);
        longint m, ua, ub, sa, sb, x, y, p, acc, q, r;
        m  = (longint'(1) << w) - 1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        sa = ua[w-1] ? ua - (longint'(1) << w) : ua;
        sb = ub[w-1] ? ub - (longint'(1) << w) : ub;
        if (op[2:1] == 2'b01) begin
            if (ub == 0) begin
                q = m;
                r = ua;
            end else if (!op[0]) begin
                if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin
                    q = longint'(1) << (w - 1);
                    r = 0;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                end
            end else begin
                q = ua / ub;
                r = ua % ub;
            end
            return {32'(r & m), 32'(q & m)};
        end
        x = op[0] ? ua : sa;
        y = op[0] ? ub : sb;
        p = x * y;
        if (op[2]) begin
            acc = ((longint'(h) & m) << w) | (longint'(l) & m);
            p   = op[1] ? acc - p : acc + p;
        end
        return {32'((p >> w) & m), 32'(p & m)};
    endfunction

    // Cycles from the start cycle to the done_o cycle.
    function automatic int exp_lat(input int w, input logic [2:0] op, input logic [31:0] b);
        longint m;
        m = (longint'(1) << w) - 1;
        return (op[2:1] == 2'b01 && (longint'(b) & m) == 0) ? 2 : w + 2;
    endfunction

    // Launches one operation on both instances and watches 40 cycles. poke issues a
    // second start mid-RUN; annul_at>0 raises annul_i during that cycle number.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l, input bit poke,
                          input int annul_at, output logic [63:0] got32, output logic [63:0] got8);
        logic [63:0] exp [2];
        logic [63:0] got [2];
        int el [2];
        int lat [2];
        int nd [2];
        bit ann [2];
        bit sbad [2];
        bit poke_en;
        for (int k = 0; k < 2; k++) begin
            exp[k]  = ref_model(w_of(k), op, a, b, h, l);
            el[k]   = exp_lat(w_of(k), op, b);
            ann[k]  = (annul_at > 0) && (annul_at < el[k]);
            lat[k]  = 0;
            nd[k]   = 0;
            sbad[k] = 1'b0;
            got[k]  = '0;
        end
        poke_en = poke && (el[0] > 6) && (el[1] > 6);
        op_i = op; opa_i = a; opb_i = b; hi_i = h; lo_i = l;
        start_i = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) check($sformatf("stall_start_w%0d", w_of(k)), stall_v[k], 1);
        @(posedge clk); #1;
        start_i = 1'b0;
        opa_i = $urandom; opb_i = $urandom; hi_i = $urandom; lo_i = $urandom;
        for (int c = 1; c <= 40; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (done_v[k]) begin
                    nd[k]++;
                    lat[k] = c;
                    got[k] = res_v[k];
                end
                if (!ann[k] && (stall_v[k] != (c < el[k]))) sbad[k] = 1'b1;
                if (ann[k] && c == annul_at + 1)
                    check($sformatf("annul_idle_w%0d", w_of(k)), {busy_v[k], done_v[k]}, 0);
            end
            start_i = poke_en && (c == 5);
            if (poke_en && c == 5) begin
                op_i = 3'($urandom);
                opa_i = $urandom;
                opb_i = $urandom;
            end
            annul_i = (c == annul_at);
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        annul_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (ann[k]) begin
                check($sformatf("annul_nodone_w%0d", w_of(k)), nd[k], 0);
                check($sformatf("annul_hold_w%0d", w_of(k)), res_v[k], exp_prev[k]);
            end else begin
                check($sformatf("latency_w%0d", w_of(k)), lat[k], el[k]);
                check($sformatf("done_count_w%0d", w_of(k)), nd[k], 1);
                check($sformatf("result_w%0d op%0d", w_of(k), op), got[k], exp[k]);
                check($sformatf("stall_w%0d", w_of(k)), sbad[k], 0);
                check($sformatf("hold_w%0d", w_of(k)), res_v[k], exp[k]);
                check($sformatf("idle_w%0d", w_of(k)), busy_v[k], 0);
                exp_prev[k] = exp[k];
            end
        end
        got32 = got[0];
        got8  = got[1];
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, h, l;
        logic [63:0] e;
    } vec_t;

    vec_t dir [8];

    initial begin
        logic [63:0] g32, g8;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        dir[0] = '{3'b000, 32'hFFFFFFFD, 32'd7,        32'd0, 32'd0,  64'hFFFFFFFF_FFFFFFEB};
        dir[1] = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'd0, 32'd0,  64'hFFFFFFFF_FFFFFFFD};
        dir[2] = '{3'b011, 32'd100,      32'd7,        32'd0, 32'd0,  64'h00000002_0000000E};
        dir[3] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0,  64'h00000000_80000000};
        dir[4] = '{3'b011, 32'h00001234, 32'd0,        32'd0, 32'd0,  64'h00001234_FFFFFFFF};
        dir[5] = '{3'b100, 32'd3,        32'd4,        32'd0, 32'd10, 64'h00000000_00000016};
        dir[6] = '{3'b111, 32'd1,        32'd1,        32'd0, 32'd0,  64'hFFFFFFFF_FFFFFFFF};
        dir[7] = '{3'b000, 32'h80,       32'h80,       32'd0, 32'd0,  64'h00000000_00004000};

        exp_prev[0] = '0;
        exp_prev[1] = '0;
        start_i = 1'b0; annul_i = 1'b0; op_i = '0;
        opa_i = '0; opb_i = '0; hi_i = '0; lo_i = '0;
        rst32 = 1'b1; rst8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_status_w%0d", w_of(k)), {busy_v[k], done_v[k], stall_v[k]}, 0);
            check($sformatf("reset_result_w%0d", w_of(k)), res_v[k], 0);
        end
        rst32 = 1'b0; rst8 = 1'b0;
        @(posedge clk); #1;

        // Directed cases with hand-computed 32-bit results
        for (int i = 0; i < 8; i++) begin
            run_op(dir[i].op, dir[i].a, dir[i].b, dir[i].h, dir[i].l, 1'b0, 0, g32, g8);
            check($sformatf("directed_%0d", i), g32, dir[i].e);
        end
        check("w8_mult_min_sq", g8, 64'h00000040_00000000);

        // Annul a MULTU at cycle 10, then restart at once with DIVU 9/3
        run_op(3'b001, $urandom, $urandom, 32'd0, 32'd0, 1'b0, 10, g32, g8);
        run_op(3'b011, 32'd9, 32'd3, 32'd0, 32'd0, 1'b0, 0, g32, g8);
        check("restart_divu", g32, 64'h00000000_00000003);

        // start together with annul in IDLE is refused
        op_i = 3'b000; opa_i = 32'd5; opb_i = 32'd6;
        start_i = 1'b1; annul_i = 1'b1;
        #1;
        check("annul_start_stall", stall_v, 0);
        @(posedge clk); #1;
        check("annul_start_busy", busy_v, 0);
        start_i = 1'b0; annul_i = 1'b0;
        @(posedge clk); #1;

        // Reset the 8-bit unit mid-RUN while annulling the 32-bit one
        op_i = 3'b000; opa_i = 32'h80; opb_i = 32'h80; hi_i = '0; lo_i = '0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("w8_running_before_rst", busy8, 1);
        rst8 = 1'b1; annul_i = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0; annul_i = 1'b0;
        check("rst_mid_w8", {busy8, done8, hi8, lo8}, 0);
        check("annul_mid_w32", {busy32, done32}, 0);
        check("annul_mid_hold_w32", res_v[0], exp_prev[0]);
        exp_prev[1] = '0;
        @(posedge clk); #1;

        // Randomized operations, biased toward divide corner cases
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: begin ra = 32'hFFFFFF80; rb = 32'hFFFFFFFF; end
                3: rb = rb & 32'hFFFFFF00;
                default: ;
            endcase
            run_op(rop, ra, rb, $urandom, $urandom, 1'($urandom), 0, g32, g8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
